alu_accum_reg: RTL and testbench

//  Result register and operand-feedback stage downstream of the ALU.

---
 rtl/alu_accum_reg_if.sv | 29 ++
 rtl/alu_accum_reg.sv | 144 ++++++++++++++
 tb/tb_alu_accum_reg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_accum_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_accum_reg_if
//  Purpose  : Control, ALU-result and display-side signals of the result
//             register / operand-feedback stage.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_accum_reg_if;
    logic       exec;
    logic       undo;
    logic       clear;
    logic [7:0] alu_out;
    logic [3:0] b_sel;
    logic [7:0] acc;
    logic       valid;
    logic       busy;
    logic [2:0] depth;

    modport master (
        output exec, undo, clear, alu_out,
        input  b_sel, acc, valid, busy, depth
    );

    modport slave (
        input  exec, undo, clear, alu_out,
        output b_sel, acc, valid, busy, depth
    );
endinterface
`default_nettype wire

// File: rtl/alu_accum_reg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_accum_reg
//  Purpose  : Accumulator capturing the ALU result after a settle delay, with
//             a bounded LIFO undo history and acc[3:0] fed back as operand B.
//  Revision : 1.0  initial release
// ============================================================================
module alu_accum_reg #(
    parameter int SETTLE_CYCLES = 1,
    parameter int HIST_DEPTH    = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    alu_accum_reg_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [2:0] HIST_MAX    = 3'(HIST_DEPTH);

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] acc_q,   acc_d;
    logic [2:0] depth_q, depth_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       exec_q,  exec_d;
    logic       undo_q,  undo_d;
    logic [7:0] hist_q [HIST_DEPTH];
    logic [7:0] hist_d [HIST_DEPTH];

    logic       exec_rise;
    logic       undo_rise;
    logic [7:0] hist_top;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        depth_d   = depth_q;
        valid_d   = valid_q;
        hist_d    = hist_q;
        exec_d    = bus.exec;
        undo_d    = bus.undo;
        exec_rise = bus.exec & ~exec_q;
        undo_rise = bus.undo & ~undo_q;

        hist_top = 8'h00;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (3'(i) == depth_q - 3'd1) begin
                hist_top = hist_q[i];
            end
        end

        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            acc_d   = 8'h00;
            depth_d = 3'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // exec wins a same-cycle collision; the undo edge is lost
                    if (exec_rise) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_INIT;
                    end else if (undo_rise && depth_q != 3'd0) begin
                        acc_d   = hist_top;
                        depth_d = depth_q - 3'd1;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    // full stack: shift out the oldest entry, newest lands on top
                    if (depth_q >= HIST_MAX) begin
                        for (int i = 0; i < HIST_DEPTH - 1; i++) begin
                            hist_d[i] = hist_q[i + 1];
                        end
                        hist_d[HIST_DEPTH - 1] = acc_q;
                    end else begin
                        for (int i = 0; i < HIST_DEPTH; i++) begin
                            if (3'(i) == depth_q) begin
                                hist_d[i] = acc_q;
                            end
                        end
                        depth_d = depth_q + 3'd1;
                    end
                    acc_d   = bus.alu_out;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= 8'h00;
            depth_q <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            exec_q  <= 1'b0;
            undo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            depth_q <= depth_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            exec_q  <= exec_d;
            undo_q  <= undo_d;
        end
    end

    // history contents are don't-care after reset; depth gates every read
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign bus.b_sel = acc_q[3:0];
    assign bus.acc   = acc_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.depth = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_accum_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_accum_reg
//  Purpose  : Directed scoreboard bench for alu_accum_reg (SETTLE_CYCLES=1,
//             HIST_DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_accum_reg;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_bad;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] acc;
        logic [2:0] depth;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    alu_accum_reg_if bus ();

    alu_accum_reg #(
        .SETTLE_CYCLES (1),
        .HIST_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] act, req;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            act = {bus.acc, bus.b_sel, bus.depth, bus.valid, bus.busy};
            req = {e.acc, e.acc[3:0], e.depth, e.valid, e.busy};
            if (e.cyc != cyc || act !== req) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (due %0d): got acc=%h b_sel=%h depth=%0d valid=%b busy=%b, want acc=%h b_sel=%h depth=%0d valid=%b busy=%b",
                         e.name, cyc, e.cyc, bus.acc, bus.b_sel, bus.depth, bus.valid, bus.busy,
                         e.acc, e.acc[3:0], e.depth, e.valid, e.busy);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input string name, input logic [7:0] a,
                             input logic [2:0] d, input logic v, input logic b);
        exp_t e;
        e.cyc = cyc + off; e.name = name; e.acc = a; e.depth = d; e.valid = v; e.busy = b;
        sb.push_back(e);
    endtask

    // single-cycle exec pulse; returns three cycles later with the commit visible
    task automatic do_exec(input logic [7:0] val, input string name,
                           input logic [7:0] a, input logic [2:0] d);
        bus.alu_out = val;
        bus.exec    = 1'b1;
        expect_at(3, name, a, d, 1'b1, 1'b0);
        step(1);
        bus.exec = 1'b0;
        step(2);
    endtask

    task automatic do_undo(input string name, input logic [7:0] a, input logic [2:0] d);
        bus.undo = 1'b1;
        expect_at(1, name, a, d, 1'b1, 1'b0);
        step(1);
        bus.undo = 1'b0;
        step(1);
    endtask

    initial begin
        cyc = 0; n_vec = 0; n_bad = 0;
        reset = 1'b1;
        bus.exec = 1'b0; bus.undo = 1'b0; bus.clear = 1'b0; bus.alu_out = 8'h00;
        step(2);
        reset = 1'b0;
        expect_at(0, "reset", 8'h00, 3'd0, 1'b0, 1'b0);
        step(1);

        // first commit and its latency window
        bus.alu_out = 8'h15;
        bus.exec    = 1'b1;
        expect_at(1, "lat_busy1", 8'h00, 3'd0, 1'b0, 1'b1);
        expect_at(2, "lat_busy2", 8'h00, 3'd0, 1'b0, 1'b1);
        expect_at(3, "lat_commit", 8'h15, 3'd1, 1'b1, 1'b0);
        step(1);
        bus.exec = 1'b0;
        step(3);

        // fill past capacity, then unwind
        do_exec(8'h01, "exec01", 8'h01, 3'd2);
        do_exec(8'h02, "exec02", 8'h02, 3'd3);
        do_exec(8'h03, "exec03", 8'h03, 3'd4);
        do_exec(8'h04, "exec04_sat", 8'h04, 3'd4);
        do_exec(8'h05, "exec05_sat", 8'h05, 3'd4);
        do_undo("undo1", 8'h04, 3'd3);
        do_undo("undo2", 8'h03, 3'd2);
        do_undo("undo3", 8'h02, 3'd1);
        do_undo("undo4", 8'h01, 3'd0);
        do_undo("undo_empty", 8'h01, 3'd0);

        // held exec produces exactly one commit
        bus.alu_out = 8'h2A;
        bus.exec    = 1'b1;
        expect_at(3,  "held_commit", 8'h2A, 3'd1, 1'b1, 1'b0);
        expect_at(6,  "held_mid",    8'h2A, 3'd1, 1'b1, 1'b0);
        expect_at(11, "held_end",    8'h2A, 3'd1, 1'b1, 1'b0);
        expect_at(13, "held_after",  8'h2A, 3'd1, 1'b1, 1'b0);
        step(10);
        bus.exec = 1'b0;
        step(4);

        // clear during SETTLE aborts the pending commit
        bus.alu_out = 8'h33;
        bus.exec    = 1'b1;
        expect_at(1, "clr_settle",  8'h2A, 3'd1, 1'b1, 1'b1);
        expect_at(2, "clr_applied", 8'h00, 3'd0, 1'b0, 1'b0);
        expect_at(4, "clr_nocommit", 8'h00, 3'd0, 1'b0, 1'b0);
        step(1);
        bus.exec    = 1'b0;
        bus.clear   = 1'b1;
        bus.alu_out = 8'h77;
        step(1);
        bus.clear = 1'b0;
        step(3);

        // exec and undo rising together: exec wins
        do_exec(8'h0A, "pre_a", 8'h0A, 3'd1);
        do_exec(8'h0B, "pre_b", 8'h0B, 3'd2);
        bus.alu_out = 8'h0C;
        bus.exec    = 1'b1;
        bus.undo    = 1'b1;
        expect_at(1, "collide_busy",   8'h0B, 3'd2, 1'b1, 1'b1);
        expect_at(3, "collide_commit", 8'h0C, 3'd3, 1'b1, 1'b0);
        step(1);
        bus.exec = 1'b0;
        bus.undo = 1'b0;
        step(2);
        do_undo("undo_after", 8'h0B, 3'd2);

        // undo edge while busy is dropped
        bus.alu_out = 8'h44;
        bus.exec    = 1'b1;
        expect_at(3, "busy_undo_drop", 8'h44, 3'd3, 1'b1, 1'b0);
        step(1);
        bus.exec = 1'b0;
        bus.undo = 1'b1;
        step(1);
        bus.undo = 1'b0;
        step(3);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
            n_bad += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
